// File: rtl/score_calculator_multi.sv
// score_calculator_multi: multi-lane reaction-game scorer.
// Each lane holds a target pattern whose point value decays over time. The
// lowest-index lane matching a user write scores pts x combo into a saturating
// global score. A lane that decays past zero expires as a miss and resets the combo.
//
// Per-lane FSM
//   state      | meaning
//   LANE_IDLE  | no target; pattern_out lane reads 0, pts held at 0
//   LANE_ARMED | target stored; pts decrement on each decay tick, miss after 0
module score_calculator_multi #(
  parameter int N_LANES   = 4,
  parameter int PAT_W     = 8,
  parameter int SCORE_W   = 11,
  parameter int MAX_PTS   = 10,
  parameter int DECAY_DIV = 1,
  parameter int COMBO_MAX = 4
) (
  input  logic                           clock100m,
  input  logic                           reset_n,
  input  logic                           clear,
  input  logic [N_LANES*PAT_W-1:0]       pattern,
  input  logic                           write100m,
  input  logic [PAT_W-1:0]               user_input,
  output logic [SCORE_W-1:0]             score_out,
  output logic [N_LANES*PAT_W-1:0]       pattern_out,
  output logic [$clog2(COMBO_MAX+1)-1:0] combo_out,
  output logic [N_LANES-1:0]             hit_pulse,
  output logic [N_LANES-1:0]             miss_pulse,
  output logic                           saturated
);

  localparam int COMBO_W = $clog2(COMBO_MAX + 1);
  localparam int PTS_W   = $clog2(MAX_PTS + 1);
  localparam int PRE_W   = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam int ADD_W   = PTS_W + COMBO_W;
  // One spare bit above the wider operand so the sum can never wrap.
  localparam int SUM_W   = ((SCORE_W > ADD_W) ? SCORE_W : ADD_W) + 1;

  typedef enum logic {
    LANE_IDLE  = 1'b0,
    LANE_ARMED = 1'b1
  } lane_state_t;

  lane_state_t        state_q [N_LANES];
  lane_state_t        state_d [N_LANES];
  logic [PAT_W-1:0]   pat_q   [N_LANES];
  logic [PAT_W-1:0]   pat_d   [N_LANES];
  logic [PTS_W-1:0]   pts_q   [N_LANES];
  logic [PTS_W-1:0]   pts_d   [N_LANES];

  logic [PRE_W-1:0]   presc_q, presc_d;
  logic               tick;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [COMBO_W-1:0] combo_q, combo_d;
  logic               sat_q, sat_d;
  logic [N_LANES-1:0] hit_q, miss_q;

  logic [N_LANES-1:0] match_vec;
  logic [N_LANES-1:0] hit_vec;
  logic [N_LANES-1:0] miss_vec;
  logic               hit_any;
  logic [PTS_W-1:0]   hit_pts;
  logic [ADD_W-1:0]   add_val;
  logic [SUM_W-1:0]   sum_val;

  // Decay prescaler: free-running 0..DECAY_DIV-1, tick on the last count.
  always_comb begin
    tick    = (presc_q == PRE_W'(DECAY_DIV - 1));
    presc_d = tick ? '0 : presc_q + PRE_W'(1);
  end

  // Match detection and lowest-index hit selection.
  always_comb begin
    match_vec = '0;
    hit_vec   = '0;
    hit_any   = 1'b0;
    hit_pts   = '0;
    for (int i = 0; i < N_LANES; i++) begin
      match_vec[i] = write100m && (state_q[i] == LANE_ARMED) &&
                     (user_input != '0) && (user_input == pat_q[i]);
      if (match_vec[i] && !hit_any) begin
        hit_vec[i] = 1'b1;
        hit_any    = 1'b1;
        hit_pts    = pts_q[i];
      end
    end
  end

  // Per-lane next state: hit > reload > decay.
  always_comb begin
    miss_vec = '0;
    for (int i = 0; i < N_LANES; i++) begin
      state_d[i] = state_q[i];
      pat_d[i]   = pat_q[i];
      pts_d[i]   = pts_q[i];
      case (state_q[i])
        LANE_IDLE: begin
          if (pattern[i*PAT_W +: PAT_W] != '0) begin
            state_d[i] = LANE_ARMED;
            pat_d[i]   = pattern[i*PAT_W +: PAT_W];
            pts_d[i]   = PTS_W'(MAX_PTS);
          end
        end
        LANE_ARMED: begin
          if (hit_vec[i]) begin
            state_d[i] = LANE_IDLE;
            pat_d[i]   = '0;
            pts_d[i]   = '0;
          end else if (pattern[i*PAT_W +: PAT_W] != '0) begin
            pat_d[i] = pattern[i*PAT_W +: PAT_W];
            pts_d[i] = PTS_W'(MAX_PTS);
          end else if (tick) begin
            if (pts_q[i] != '0) begin
              pts_d[i] = pts_q[i] - PTS_W'(1);
            end else begin
              state_d[i]  = LANE_IDLE;
              pat_d[i]    = '0;
              miss_vec[i] = 1'b1;
            end
          end
        end
        default: begin
          state_d[i] = LANE_IDLE;
          pat_d[i]   = '0;
          pts_d[i]   = '0;
        end
      endcase
    end
  end

  // Score accumulation with clamp, and combo update (a miss anywhere wins).
  always_comb begin
    add_val = ADD_W'(hit_pts) * ADD_W'(combo_q);
    sum_val = SUM_W'(score_q) + SUM_W'(add_val);
    score_d = score_q;
    sat_d   = sat_q;
    if (hit_any) begin
      if (sum_val[SUM_W-1:SCORE_W] != '0) begin
        score_d = '1;
        sat_d   = 1'b1;
      end else begin
        score_d = sum_val[SCORE_W-1:0];
      end
    end
    combo_d = combo_q;
    if (miss_vec != '0) begin
      combo_d = COMBO_W'(1);
    end else if (hit_any) begin
      combo_d = (combo_q >= COMBO_W'(COMBO_MAX)) ? COMBO_W'(COMBO_MAX)
                                                 : combo_q + COMBO_W'(1);
    end
  end

  // State register; clear behaves exactly like reset.
  always_ff @(posedge clock100m) begin
    if (!reset_n || clear) begin
      for (int i = 0; i < N_LANES; i++) begin
        state_q[i] <= LANE_IDLE;
        pat_q[i]   <= '0;
        pts_q[i]   <= '0;
      end
      presc_q <= '0;
      score_q <= '0;
      combo_q <= COMBO_W'(1);
      sat_q   <= 1'b0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      for (int i = 0; i < N_LANES; i++) begin
        state_q[i] <= state_d[i];
        pat_q[i]   <= pat_d[i];
        pts_q[i]   <= pts_d[i];
      end
      presc_q <= presc_d;
      score_q <= score_d;
      combo_q <= combo_d;
      sat_q   <= sat_d;
      hit_q   <= hit_vec;
      miss_q  <= miss_vec;
    end
  end

  genvar g;
  generate
    for (g = 0; g < N_LANES; g++) begin : g_pat_out
      assign pattern_out[g*PAT_W +: PAT_W] = pat_q[g];
    end
  endgenerate

  assign score_out  = score_q;
  assign combo_out  = combo_q;
  assign hit_pulse  = hit_q;
  assign miss_pulse = miss_q;
  assign saturated  = sat_q;

endmodule

// File: tb/tb_score_calculator_multi.sv
// Bench for score_calculator_multi: two instances (fast decay / wide score and
// slow decay / 5-bit score) share one stimulus stream; a reference model per
// instance queues expected outputs and a negedge monitor compares them.
module tb_score_calculator_multi;

  localparam int N    = 4;
  localparam int PW   = 8;
  localparam int MAXP = 10;
  localparam int CMAX = 4;

  logic clock100m = 1'b0;
  always #5 clock100m = ~clock100m;

  logic            reset_n = 1'b0;
  logic            clear = 1'b0;
  logic [N*PW-1:0] pattern = '0;
  logic            write100m = 1'b0;
  logic [PW-1:0]   user_input = '0;

  logic [10:0]     score_a;
  logic [4:0]      score_b;
  logic [N*PW-1:0] pat_a, pat_b;
  logic [2:0]      combo_a, combo_b;
  logic [N-1:0]    hit_a, hit_b, miss_a, miss_b;
  logic            sat_a, sat_b;

  score_calculator_multi #(.N_LANES(N), .PAT_W(PW), .SCORE_W(11), .MAX_PTS(MAXP),
                           .DECAY_DIV(1), .COMBO_MAX(CMAX)) dut_a (
    .clock100m(clock100m), .reset_n(reset_n), .clear(clear), .pattern(pattern),
    .write100m(write100m), .user_input(user_input), .score_out(score_a),
    .pattern_out(pat_a), .combo_out(combo_a), .hit_pulse(hit_a),
    .miss_pulse(miss_a), .saturated(sat_a));

  score_calculator_multi #(.N_LANES(N), .PAT_W(PW), .SCORE_W(5), .MAX_PTS(MAXP),
                           .DECAY_DIV(3), .COMBO_MAX(CMAX)) dut_b (
    .clock100m(clock100m), .reset_n(reset_n), .clear(clear), .pattern(pattern),
    .write100m(write100m), .user_input(user_input), .score_out(score_b),
    .pattern_out(pat_b), .combo_out(combo_b), .hit_pulse(hit_b),
    .miss_pulse(miss_b), .saturated(sat_b));

  typedef struct {
    int              score;
    logic [N*PW-1:0] pat;
    int              combo;
    logic [N-1:0]    hit;
    logic [N-1:0]    miss;
    bit              sat;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  // Reference model state, index 0 = dut_a, 1 = dut_b.
  int           m_div  [2] = '{1, 3};
  int           m_smax [2] = '{2047, 31};
  bit           m_armed[2][N];
  int           m_pat  [2][N];
  int           m_pts  [2][N];
  int           m_score[2];
  int           m_combo[2];
  int           m_presc[2];
  bit           m_sat  [2];
  logic [N-1:0] m_hit  [2];
  logic [N-1:0] m_miss [2];

  task automatic model_step(input int k);
    int  hl;
    int  total;
    int  p;
    bit  tick;
    m_hit[k]  = '0;
    m_miss[k] = '0;
    if (!reset_n || clear) begin
      for (int i = 0; i < N; i++) begin
        m_armed[k][i] = 0;
        m_pat[k][i]   = 0;
        m_pts[k][i]   = 0;
      end
      m_score[k] = 0;
      m_combo[k] = 1;
      m_presc[k] = 0;
      m_sat[k]   = 0;
    end else begin
      tick = (m_presc[k] == m_div[k] - 1);
      m_presc[k] = tick ? 0 : m_presc[k] + 1;
      hl = -1;
      for (int i = 0; i < N; i++)
        if (hl < 0 && write100m && m_armed[k][i] && user_input != 0 &&
            int'(user_input) == m_pat[k][i])
          hl = i;
      if (hl >= 0) begin
        total = m_score[k] + m_pts[k][hl] * m_combo[k];
        if (total > m_smax[k]) begin
          m_score[k] = m_smax[k];
          m_sat[k]   = 1;
        end else begin
          m_score[k] = total;
        end
      end
      for (int i = 0; i < N; i++) begin
        p = int'(pattern[i*PW +: PW]);
        if (!m_armed[k][i]) begin
          if (p != 0) begin
            m_armed[k][i] = 1; m_pat[k][i] = p; m_pts[k][i] = MAXP;
          end
        end else if (i == hl) begin
          m_armed[k][i] = 0; m_pat[k][i] = 0; m_pts[k][i] = 0; m_hit[k][i] = 1'b1;
        end else if (p != 0) begin
          m_pat[k][i] = p; m_pts[k][i] = MAXP;
        end else if (tick) begin
          if (m_pts[k][i] > 0) m_pts[k][i]--;
          else begin
            m_armed[k][i] = 0; m_pat[k][i] = 0; m_miss[k][i] = 1'b1;
          end
        end
      end
      if (m_miss[k] != 0)  m_combo[k] = 1;
      else if (hl >= 0)    m_combo[k] = (m_combo[k] + 1 > CMAX) ? CMAX : m_combo[k] + 1;
    end
  endtask

  function automatic exp_t snap(input int k);
    exp_t e;
    int   v;
    e.score = m_score[k];
    e.combo = m_combo[k];
    e.hit   = m_hit[k];
    e.miss  = m_miss[k];
    e.sat   = m_sat[k];
    e.pat   = '0;
    for (int i = 0; i < N; i++) begin
      v = m_pat[k][i];
      e.pat[i*PW +: PW] = v[PW-1:0];
    end
    return e;
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every cycle the DUTs present a full output set; pop and compare.
  exp_t ea, eb;
  always @(negedge clock100m) begin
    if (q_a.size() > 0) begin
      ea = q_a.pop_front();
      cmp("a.score",   64'(score_a), 64'(ea.score));
      cmp("a.pattern", 64'(pat_a),   64'(ea.pat));
      cmp("a.combo",   64'(combo_a), 64'(ea.combo));
      cmp("a.hit",     64'(hit_a),   64'(ea.hit));
      cmp("a.miss",    64'(miss_a),  64'(ea.miss));
      cmp("a.sat",     64'(sat_a),   64'(ea.sat));
    end
    if (q_b.size() > 0) begin
      eb = q_b.pop_front();
      cmp("b.score",   64'(score_b), 64'(eb.score));
      cmp("b.pattern", 64'(pat_b),   64'(eb.pat));
      cmp("b.combo",   64'(combo_b), 64'(eb.combo));
      cmp("b.hit",     64'(hit_b),   64'(eb.hit));
      cmp("b.miss",    64'(miss_b),  64'(eb.miss));
      cmp("b.sat",     64'(sat_b),   64'(eb.sat));
    end
  end

  task automatic step();
    model_step(0);
    model_step(1);
    @(posedge clock100m);
    q_a.push_back(snap(0));
    q_b.push_back(snap(1));
    cyc++;
    #1;
  endtask

  task automatic idle_inputs();
    reset_n = 1'b1; clear = 1'b0; pattern = '0; write100m = 1'b0; user_input = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      idle_inputs();
      step();
    end
  endtask

  task automatic load(input int lane, input logic [PW-1:0] p);
    idle_inputs();
    pattern[lane*PW +: PW] = p;
    step();
  endtask

  task automatic wr(input logic [PW-1:0] v);
    idle_inputs();
    write100m = 1'b1; user_input = v;
    step();
  endtask

  function automatic logic [PW-1:0] pick_pat();
    logic [PW-1:0] set4 [4] = '{8'h81, 8'h3C, 8'h0F, 8'h55};
    if ($urandom_range(0, 3) == 0) return PW'($urandom_range(1, 255));
    return set4[$urandom_range(0, 3)];
  endfunction

  int lane_r;

  initial begin
    // Reset, then reset and clear with lanes armed.
    reset_n = 1'b0; step(); step();
    idle_inputs(); pattern = {8'h12, 8'h34, 8'h56, 8'h78}; step();
    idle(2);
    reset_n = 1'b0; step();
    idle_inputs(); pattern = {8'h12, 8'h34, 8'h56, 8'h78}; step();
    idle(1);
    idle_inputs(); clear = 1'b1; step();
    idle(2);

    // Single hit and combo build-up.
    for (int r = 0; r < 5; r++) begin
      load(0, 8'h81);
      idle(2);
      wr(8'h81);
    end

    // Expiry on lane 2 with no writes.
    load(2, 8'h0F);
    idle(40);

    // Raise combo, then lane0 expiry coinciding with lane1 hit (lane3 also matches).
    load(0, 8'h81); wr(8'h81);
    load(0, 8'h81); wr(8'h81);
    load(0, 8'h11);
    idle(4);
    idle_inputs(); pattern[1*PW +: PW] = 8'h3C; pattern[3*PW +: PW] = 8'h3C; step();
    idle(5);
    wr(8'h3C);
    idle(3);
    wr(8'h3C);
    idle(40);

    // Saturation in both instances, then zero and non-matching writes.
    for (int r = 0; r < 70; r++) begin
      load(0, 8'h81);
      wr(8'h81);
    end
    load(1, 8'h22);
    wr(8'h00);
    wr(8'h23);
    wr(8'h22);
    idle(3);

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      idle_inputs();
      case ($urandom_range(0, 299))
        0: reset_n = 1'b0;
        1: clear = 1'b1;
        default: ;
      endcase
      for (int l = 0; l < N; l++)
        if ($urandom_range(0, 9) == 0) pattern[l*PW +: PW] = pick_pat();
      if ($urandom_range(0, 2) == 0) begin
        write100m = 1'b1;
        lane_r = $urandom_range(0, N - 1);
        case ($urandom_range(0, 5))
          0:       user_input = '0;
          1:       user_input = PW'($urandom_range(0, 255));
          default: user_input = m_armed[0][lane_r] ? PW'(m_pat[0][lane_r]) : pick_pat();
        endcase
      end
      step();
    end

    idle(2);
    repeat (3) @(negedge clock100m);
    #1;
    tests++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d/%0d pending expected 0/0", q_a.size(), q_b.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
